// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter that shares one two-stage 8x8 unsigned
// multiplier between NUM_REQ requesters and returns id-tagged 16-bit products.
// A stalled response output back-pressures both pipeline stages.
// Optional feature: define MUL_ARB_STATS_EN to add per-requester saturating
// grant counters readable through stat_sel/stat_count.
module mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [15:0]            rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
`ifdef MUL_ARB_STATS_EN
    ,
    input  logic [ID_W-1:0]        stat_sel,
    output logic [15:0]            stat_count
`endif
);

    // Stage S1: operand buffers
    logic              v1_reg;
    logic [7:0]        a_buf_reg;
    logic [7:0]        b_buf_reg;
    logic [ID_W-1:0]   id1_reg;

    // Stage S2: product
    logic              v2_reg;
    logic [15:0]       prod_reg;
    logic [ID_W-1:0]   id2_reg;

    // Index of the last granted requester
    logic [ID_W-1:0]   ptr_reg;

    logic [NUM_REQ-1:0][7:0] op_a;
    logic [NUM_REQ-1:0][7:0] op_b;

    logic              stall2;
    logic              adv1;
    logic              can_accept;
    logic              found_next;
    logic [ID_W-1:0]   winner_next;
    logic              grant_ok;
    logic              accept;

    assign op_a = req_a;
    assign op_b = req_b;

    assign stall2     = v2_reg & ~rsp_ready;
    assign adv1       = v1_reg & ~stall2;
    assign can_accept = ~v1_reg | ~stall2;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        found_next  = 1'b0;
        winner_next = ptr_reg;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!found_next && req_valid[ID_W'((int'(ptr_reg) + off) % NUM_REQ)]) begin
                found_next  = 1'b1;
                winner_next = ID_W'((int'(ptr_reg) + off) % NUM_REQ);
            end
        end
    end

    // Reset suppresses grants so a coinciding request is never taken
    assign grant_ok = found_next & can_accept & ~reset;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_ok && (winner_next == ID_W'(gi));
        end
    endgenerate

    assign accept = |(req_valid & req_ready);

    // Pipeline registers and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_reg    <= 1'b0;
            a_buf_reg <= 8'd0;
            b_buf_reg <= 8'd0;
            id1_reg   <= '0;
            v2_reg    <= 1'b0;
            prod_reg  <= 16'd0;
            id2_reg   <= '0;
            ptr_reg   <= ID_W'(NUM_REQ - 1);
        end else begin
            if (accept) begin
                a_buf_reg <= op_a[winner_next];
                b_buf_reg <= op_b[winner_next];
                id1_reg   <= winner_next;
                v1_reg    <= 1'b1;
                ptr_reg   <= winner_next;
            end else if (adv1) begin
                v1_reg    <= 1'b0;
            end

            if (adv1) begin
                prod_reg <= {8'd0, a_buf_reg} * {8'd0, b_buf_reg};
                id2_reg  <= id1_reg;
                v2_reg   <= 1'b1;
            end else if (v2_reg && rsp_ready) begin
                v2_reg   <= 1'b0;
            end
        end
    end

    assign rsp_valid = v2_reg;
    assign rsp_data  = prod_reg;
    assign rsp_id    = id2_reg;
    assign busy      = v1_reg | v2_reg;

`ifdef MUL_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt_all;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            logic [15:0] cnt_reg;

            // Saturating count of handshakes for this requester
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= 16'd0;
                end else if (req_valid[gi] && req_ready[gi] && cnt_reg != 16'hFFFF) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end

            assign cnt_all[gi] = cnt_reg;
        end
    endgenerate

    assign stat_count = cnt_all[stat_sel];
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed stimulus for mul_share_arb with a queue-based
// reference model checked every cycle, plus literal expectations per scenario.
module tb_mul_share_arb;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [8*N-1:0]  req_a;
    logic [8*N-1:0]  req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [15:0]     rsp_data;
    logic [IW-1:0]   rsp_id;
    logic            busy;
`ifdef MUL_ARB_STATS_EN
    logic [IW-1:0]   stat_sel;
    logic [15:0]     stat_count;
`endif

    always #5 clk = ~clk;

    mul_share_arb #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef MUL_ARB_STATS_EN
        ,
        .stat_sel  (stat_sel),
        .stat_count(stat_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endfunction

    function automatic int qget(input int qq[$], input int k);
        return (k < qq.size()) ? qq[k] : -1;
    endfunction

    // Reference model: in-flight entries in grant order, each with the
    // number of edges since it was accepted (head is visible at 2 or more).
    typedef struct {
        int id;
        int prod;
        int age;
    } ent_t;

    ent_t       q[$];
    int         last = N - 1;
    int         cnt[N];
    int         m_win;
    bit         m_can;
    logic [N-1:0] m_er;
    bit         m_ev;
    int         cyc = 0;
    logic [N-1:0] hs_vec = '0;

    // Observation logs for the literal checks
    int grant_log[$];
    int grant_cyc[$];
    int rsp_log[$];
    int rsp_cyc[$];

    task automatic clear_logs();
        grant_log.delete();
        grant_cyc.delete();
        rsp_log.delete();
        rsp_cyc.delete();
    endtask

    // Per-cycle compare against the model, then advance the model one edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            hs_vec = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (hs_vec[i]) begin
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                end
            end
            if (!reset && rsp_valid && rsp_ready) begin
                rsp_log.push_back(int'(rsp_id) * 65536 + int'(rsp_data));
                rsp_cyc.push_back(cyc);
            end

            if (reset) begin
                check("ready_in_reset", 32'(req_ready), 32'd0);
                q.delete();
                last = N - 1;
                for (int i = 0; i < N; i++) cnt[i] = 0;
            end else begin
                m_win = -1;
                for (int off = 1; off <= N; off++) begin
                    if (m_win < 0 && req_valid[(last + off) % N]) m_win = (last + off) % N;
                end
                m_can = (q.size() < 2) || rsp_ready;
                m_er  = '0;
                if (m_win >= 0 && m_can) m_er[m_win] = 1'b1;
                m_ev  = (q.size() > 0) && (q[0].age >= 2);

                check("req_ready", 32'(req_ready), 32'(m_er));
                check("rsp_valid", 32'(rsp_valid), 32'(m_ev));
                check("busy", 32'(busy), 32'(q.size() > 0));
                if (m_ev) begin
                    check("rsp_data", 32'(rsp_data), 32'(q[0].prod));
                    check("rsp_id", 32'(rsp_id), 32'(q[0].id));
                end
`ifdef MUL_ARB_STATS_EN
                check("stat_count", 32'(stat_count), 32'(cnt[stat_sel]));
`endif
                if (m_ev && rsp_ready) void'(q.pop_front());
                foreach (q[k]) q[k].age++;
                if (m_er != '0) begin
                    q.push_back('{m_win, int'(req_a[8*m_win +: 8]) * int'(req_b[8*m_win +: 8]), 1});
                    last = m_win;
                    if (cnt[m_win] < 65535) cnt[m_win]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    // Directed scenarios
    initial begin
        int nexta;
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
`ifdef MUL_ARB_STATS_EN
        stat_sel  = '0;
`endif
        do_reset(3);

        // Outputs straight after reset
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();

        // Single request 12*13
        clear_logs();
        req_a[7:0] = 8'd12;
        req_b[7:0] = 8'd13;
        req_valid  = 4'b0001;
        @(negedge clk);
        check("t1_ready_same_cycle", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("t1_rsp", 32'(qget(rsp_log, 0)), 32'd156);
        check("t1_latency", 32'(qget(rsp_cyc, 0) - qget(grant_cyc, 0)), 32'd2);
        check("t1_busy_idle", 32'(busy), 32'd0);

        // All four valid for 8 cycles
        do_reset(1);
        clear_logs();
        for (int i = 0; i < N; i++) begin
            req_a[8*i +: 8] = 8'(i + 1);
            req_b[8*i +: 8] = 8'd10;
        end
        req_valid = 4'hF;
        repeat (8) tick();
        req_valid = '0;
        repeat (4) tick();
        check("t2_grants", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check("t2_grant_order", 32'(qget(grant_log, k)), 32'(k % 4));
            check("t2_rsp", 32'(qget(rsp_log, k)), 32'((k % 4) * 65536 + (k % 4 + 1) * 10));
            check("t2_rate", 32'(qget(rsp_cyc, k) - qget(rsp_cyc, 0)), 32'(k));
        end

        // Corner operands back to back
        do_reset(1);
        clear_logs();
        req_valid  = 4'b0001;
        req_a[7:0] = 8'd255; req_b[7:0] = 8'd255;
        tick();
        req_a[7:0] = 8'd255; req_b[7:0] = 8'd0;
        tick();
        req_a[7:0] = 8'd1;   req_b[7:0] = 8'd255;
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("t3_count", 32'(rsp_log.size()), 32'd3);
        check("t3_ff", 32'(qget(rsp_log, 0)), 32'h0000_FE01);
        check("t3_zero", 32'(qget(rsp_log, 1)), 32'h0000_0000);
        check("t3_one", 32'(qget(rsp_log, 2)), 32'h0000_00FF);

        // Back-pressure with a continuous req1 stream
        do_reset(1);
        clear_logs();
        rsp_ready   = 1'b0;
        nexta       = 1;
        req_a[15:8] = 8'd1;
        req_b[15:8] = 8'd3;
        req_valid   = 4'b0010;
        repeat (5) begin
            tick();
            if (hs_vec[1]) begin
                nexta++;
                req_a[15:8] = 8'(nexta);
            end
        end
        check("t4_stall_grants", 32'(grant_log.size()), 32'd2);
        check("t4_stall_ready", 32'(req_ready), 32'd0);
        check("t4_stall_valid", 32'(rsp_valid), 32'd1);
        check("t4_stall_data", 32'(rsp_data), 32'd3);
        rsp_ready = 1'b1;
        repeat (4) begin
            tick();
            if (hs_vec[1]) begin
                nexta++;
                req_a[15:8] = 8'(nexta);
            end
        end
        req_valid = '0;
        repeat (4) tick();
        check("t4_total_grants", 32'(grant_log.size()), 32'd6);
        check("t4_rsp_count", 32'(rsp_log.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check("t4_rsp_order", 32'(qget(rsp_log, k)), 32'(65536 + (k + 1) * 3));
        end

        // Reset with both stages full
        do_reset(1);
        clear_logs();
        rsp_ready  = 1'b0;
        req_a[7:0] = 8'd5;
        req_b[7:0] = 8'd5;
        req_valid  = 4'b0001;
        repeat (2) tick();
        req_a[7:0]   = 8'd2; req_b[7:0]   = 8'd2;
        req_a[31:24] = 8'd3; req_b[31:24] = 8'd3;
        req_valid = 4'b1001;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t5_rsp_valid_after_rst", 32'(rsp_valid), 32'd0);
        check("t5_first_grant", 32'(req_ready), 32'b0001);
        tick();
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("t5_grant0", 32'(qget(grant_log, 2)), 32'd0);
        check("t5_grant3", 32'(qget(grant_log, 3)), 32'd3);
        check("t5_rsp_count", 32'(rsp_log.size()), 32'd2);
        check("t5_rsp0", 32'(qget(rsp_log, 0)), 32'd4);
        check("t5_rsp1", 32'(qget(rsp_log, 1)), 32'(3 * 65536 + 9));

`ifdef MUL_ARB_STATS_EN
        // Grant counters
        do_reset(1);
        req_a[23:16] = 8'd1; req_b[23:16] = 8'd1;
        req_valid = 4'b0100;
        repeat (3) tick();
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (3) tick();
        stat_sel = 2'd2;
        #1 check("stat_req2", 32'(stat_count), 32'd3);
        stat_sel = 2'd0;
        #1 check("stat_req0", 32'(stat_count), 32'd1);
        do_reset(1);
        check("stat_req0_rst", 32'(stat_count), 32'd0);
        stat_sel = 2'd2;
        #1 check("stat_req2_rst", 32'(stat_count), 32'd0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound on the whole run
    initial begin
        #200000;
        $display("FAIL timeout got %0d expected %0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
